// File: rtl/mrc_pkg.sv
`default_nettype none
// ============================================================
// Package  : mrc_pkg - shared encodings and defaults for the MRC host
// Revision : 1.0
// ============================================================
package mrc_pkg;

  localparam int c_DEFAULT_WORD_LENGTH    = 16;
  localparam int c_DEFAULT_TIMEOUT_CYCLES = 255;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_SQRT = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_WAIT_X   = 3'd2,
    ST_LOAD_X   = 3'd3,
    ST_WAIT_Y   = 3'd4,
    ST_LOAD_Y   = 3'd5,
    ST_WAIT_RDY = 3'd6,
    ST_RESP     = 3'd7
  } host_state_t;

  function automatic logic is_wait_state(input host_state_t s);
    return (s == ST_WAIT_X) || (s == ST_WAIT_Y) || (s == ST_WAIT_RDY);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mrc_timeout_cnt.sv
`default_nettype none
// ============================================================
// Module   : mrc_timeout_cnt - per-wait watchdog, expires at TIMEOUT_CYCLES-1
// Revision : 1.0
// ============================================================
module mrc_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int              c_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [c_W-1:0]  c_TERM = c_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_W-1:0]  c_ONE  = c_W'(1);

  logic [c_W-1:0] r_count;

  // Holds at the terminal count so a lingering enable cannot wrap it.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (enable && !expired) begin
      r_count <= r_count + c_ONE;
    end
  end

  assign expired = (r_count == c_TERM);

endmodule
`default_nettype wire

// File: rtl/mrc_host.sv
`default_nettype none
// ============================================================
// Module   : mrc_host - request/response initiator driving the MRC unit
// Revision : 1.0
// ============================================================
module mrc_host
  import mrc_pkg::*;
#(
  parameter int WORD_LENGTH    = c_DEFAULT_WORD_LENGTH,
  parameter int TIMEOUT_CYCLES = c_DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_op,
  input  logic [WORD_LENGTH-1:0]     req_a,
  input  logic [WORD_LENGTH-1:0]     req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [2*WORD_LENGTH-1:0]   rsp_result,
  output logic                       rsp_error,
  output logic                       rsp_timeout,
  output logic                       busy,
  output logic                       mrc_start,
  output logic                       mrc_load,
  output logic [WORD_LENGTH-1:0]     mrc_data,
  output logic                       mrc_op,
  input  logic                       mrc_x,
  input  logic                       mrc_y,
  input  logic                       mrc_ready,
  input  logic [2*WORD_LENGTH-1:0]   mrc_result,
  input  logic                       mrc_error
);

  host_state_t                r_state;
  host_state_t                w_next;

  logic                       r_op;
  logic [WORD_LENGTH-1:0]     r_a;
  logic [WORD_LENGTH-1:0]     r_b;
  logic [2*WORD_LENGTH-1:0]   r_result;
  logic                       r_error;
  logic                       r_timeout;

  logic                       w_in_wait;
  logic                       w_event;
  logic                       w_expired;
  logic                       w_timeout_hit;
  logic                       w_accept;
  logic                       w_state_change;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // The awaited event always takes precedence over the watchdog.
  always_comb begin
    w_next    = r_state;
    w_event   = 1'b0;
    w_in_wait = is_wait_state(r_state);
    case (r_state)
      ST_IDLE: begin
        if (req_valid) w_next = ST_START;
      end
      ST_START: begin
        w_next = ST_WAIT_X;
      end
      ST_WAIT_X: begin
        w_event = mrc_x;
        if (w_event)        w_next = ST_LOAD_X;
        else if (w_expired) w_next = ST_RESP;
      end
      ST_LOAD_X: begin
        w_next = (r_op == OP_MULT) ? ST_WAIT_Y : ST_WAIT_RDY;
      end
      ST_WAIT_Y: begin
        // The unit must have dropped x before the second operand is taken.
        w_event = mrc_y && !mrc_x;
        if (w_event)        w_next = ST_LOAD_Y;
        else if (w_expired) w_next = ST_RESP;
      end
      ST_LOAD_Y: begin
        w_next = ST_WAIT_RDY;
      end
      ST_WAIT_RDY: begin
        w_event = mrc_ready;
        if (w_event)        w_next = ST_RESP;
        else if (w_expired) w_next = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  assign w_timeout_hit  = w_in_wait && !w_event && w_expired;
  assign w_accept       = (r_state == ST_IDLE) && req_valid;
  assign w_state_change = (w_next != r_state);

  mrc_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_state_change),
    .enable  (w_in_wait && !w_event),
    .expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op      <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_result  <= '0;
      r_error   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op      <= req_op;
        r_a       <= req_a;
        r_b       <= req_b;
        r_result  <= '0;
        r_error   <= 1'b0;
        r_timeout <= 1'b0;
      end
      if ((r_state == ST_WAIT_RDY) && mrc_ready) begin
        r_result <= mrc_result;
        r_error  <= mrc_error;
      end else if (w_timeout_hit) begin
        r_result  <= '0;
        r_error   <= 1'b1;
        r_timeout <= 1'b1;
      end
    end
  end

  always_comb begin
    mrc_data = '0;
    case (r_state)
      ST_WAIT_X, ST_LOAD_X: mrc_data = r_a;
      ST_WAIT_Y, ST_LOAD_Y: mrc_data = r_b;
      default:              mrc_data = '0;
    endcase
  end

  assign req_ready   = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign rsp_valid   = (r_state == ST_RESP);
  assign mrc_start   = (r_state == ST_START);
  assign mrc_load    = (r_state == ST_LOAD_X) || (r_state == ST_LOAD_Y);
  assign mrc_op      = r_op && (r_state != ST_IDLE) && (r_state != ST_RESP);
  assign rsp_result  = r_result;
  assign rsp_error   = r_error;
  assign rsp_timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_mrc_host.sv
`default_nettype none
// ============================================================
// Module   : tb_mrc_host - scoreboard bench with a behavioural MRC unit model
// Revision : 1.0
// ============================================================
module tb_mrc_host;
  import mrc_pkg::*;

  localparam int WL = 16;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid;
  logic            req_ready;
  logic            req_op;
  logic [WL-1:0]   req_a;
  logic [WL-1:0]   req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [2*WL-1:0] rsp_result;
  logic            rsp_error;
  logic            rsp_timeout;
  logic            busy;
  logic            mrc_start;
  logic            mrc_load;
  logic [WL-1:0]   mrc_data;
  logic            mrc_op;
  logic            mrc_x = 1'b0;
  logic            mrc_y = 1'b0;
  logic            mrc_ready = 1'b0;
  logic [2*WL-1:0] mrc_result = '0;
  logic            mrc_error = 1'b0;

  mrc_host #(.WORD_LENGTH(WL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout), .busy(busy),
    .mrc_start(mrc_start), .mrc_load(mrc_load), .mrc_data(mrc_data), .mrc_op(mrc_op),
    .mrc_x(mrc_x), .mrc_y(mrc_y), .mrc_ready(mrc_ready),
    .mrc_result(mrc_result), .mrc_error(mrc_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2*WL-1:0] res;
    logic            err;
    logic            to;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Model configuration (changed only while the host is idle)
  int              m_x_dly = 1, m_y_dly = 2, m_r_dly = 1;
  bit              m_never_y = 0, m_never_r = 0, m_stray = 0, m_err = 0;
  logic [2*WL-1:0] m_result = '0;

  // Model state and observation
  int            x_cnt = -1, y_cnt = -1, r_cnt = -1, loads_this = 0;
  bit            stray_pend = 0;
  int            start_count = 0, load_count = 0, load_cycle = 0;
  logic          start_op = 1'b0;
  logic [WL-1:0] load_q[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!busy) begin
      x_cnt = -1; y_cnt = -1; r_cnt = -1; loads_this = 0; stray_pend = 0;
    end else if (mrc_start) begin
      start_count++;
      start_op = mrc_op;
      x_cnt = m_x_dly; y_cnt = -1; r_cnt = -1; loads_this = 0;
    end else if (mrc_load) begin
      load_count++;
      loads_this++;
      load_q.push_back(mrc_data);
      load_cycle = cyc;
      if (loads_this == 1) begin
        x_cnt = -1;
        if (mrc_op) begin
          r_cnt = m_never_r ? -1 : m_r_dly;
        end else begin
          y_cnt = m_never_y ? -1 : m_y_dly;
          stray_pend = m_stray;
        end
      end else begin
        y_cnt = -1;
        r_cnt = m_never_r ? -1 : m_r_dly;
      end
    end else begin
      if (x_cnt > 0) x_cnt--;
      if (y_cnt > 0) y_cnt--;
      if (r_cnt > 0) r_cnt--;
    end
    mrc_x = (x_cnt == 0);
    mrc_y = (y_cnt == 0);
    if (stray_pend && !mrc_load) begin
      mrc_ready  = 1'b1;
      mrc_result = 32'hDEAD_BEEF;
      mrc_error  = 1'b0;
      stray_pend = 0;
    end else begin
      mrc_ready  = (r_cnt == 0);
      mrc_result = m_result;
      mrc_error  = (r_cnt == 0) && m_err;
    end
  end

  task automatic set_model(input int xd, input int yd, input int rd, input bit ny,
                           input bit nr, input bit st, input bit er, input logic [2*WL-1:0] res);
    m_x_dly = xd; m_y_dly = yd; m_r_dly = rd;
    m_never_y = ny; m_never_r = nr; m_stray = st; m_err = er; m_result = res;
  endtask

  task automatic send_req(input logic op, input logic [WL-1:0] a, input logic [WL-1:0] b);
    int n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL req_accept: req_ready=%b required 1", req_ready);
    end
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(negedge clk);
    req_valid = 1'b0; req_op = 1'b0; req_a = '0; req_b = '0;
  endtask

  task automatic wait_rsp(output int lat, output bit ok);
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    ok = (rsp_valid === 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_req_ready: got %b required 1", req_ready);
    end
    checks++;
    if ({busy, rsp_valid, rsp_error, rsp_timeout, mrc_start, mrc_load, mrc_op} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 0000000",
               {busy, rsp_valid, rsp_error, rsp_timeout, mrc_start, mrc_load, mrc_op});
    end
    checks++;
    if (rsp_result !== '0 || mrc_data !== '0) begin
      errors++; $display("FAIL reset_data: rsp_result=%h mrc_data=%h required 0", rsp_result, mrc_data);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mult();
    exp_t e; int lat; bit ok; int s0, l0;
    set_model(2, 2, 3, 0, 0, 0, 0, 32'hFFFF_FFFA);
    s0 = start_count; l0 = load_count; load_q.delete();
    e.res = 32'hFFFF_FFFA; e.err = 1'b0; e.to = 1'b0; sb.push_back(e);
    send_req(OP_MULT, 16'h0003, 16'hFFFE);
    wait_rsp(lat, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mult_rsp_valid: got %b required 1", rsp_valid); end
    e = sb.pop_front();
    checks++;
    if (rsp_result !== e.res || rsp_error !== e.err || rsp_timeout !== e.to) begin
      errors++;
      $display("FAIL mult_rsp: got %h/%b/%b required %h/%b/%b",
               rsp_result, rsp_error, rsp_timeout, e.res, e.err, e.to);
    end
    checks++;
    if (start_count - s0 != 1 || load_count - l0 != 2) begin
      errors++;
      $display("FAIL mult_pulses: starts=%0d loads=%0d required 1 and 2", start_count - s0, load_count - l0);
    end
    checks++;
    if (load_q.size() != 2) begin
      errors++; $display("FAIL mult_load_data: %0d loads recorded required 2", load_q.size());
    end else if (load_q[0] !== 16'h0003 || load_q[1] !== 16'hFFFE) begin
      errors++; $display("FAIL mult_load_data: got %h,%h required 0003,fffe", load_q[0], load_q[1]);
    end
    checks++;
    if (start_op !== OP_MULT) begin errors++; $display("FAIL mult_op: got %b required 0", start_op); end
    @(negedge clk);
  endtask

  task automatic test_sqrt();
    exp_t e; int lat; bit ok; int l0;
    set_model(1, 2, 1, 0, 0, 0, 0, 32'h0000_0009);
    l0 = load_count; load_q.delete();
    e.res = 32'h0000_0009; e.err = 1'b0; e.to = 1'b0; sb.push_back(e);
    send_req(OP_SQRT, 16'h0051, 16'h1111);
    wait_rsp(lat, ok);
    checks++;
    if (!ok || lat != 5) begin
      errors++; $display("FAIL sqrt_latency: got %0d (valid=%b) required 5", lat, rsp_valid);
    end
    e = sb.pop_front();
    checks++;
    if (rsp_result !== e.res || rsp_error !== e.err || rsp_timeout !== e.to) begin
      errors++;
      $display("FAIL sqrt_rsp: got %h/%b/%b required %h/%b/%b",
               rsp_result, rsp_error, rsp_timeout, e.res, e.err, e.to);
    end
    checks++;
    if (load_count - l0 != 1 || load_q.size() != 1) begin
      errors++; $display("FAIL sqrt_loads: got %0d required 1", load_count - l0);
    end else if (load_q[0] !== 16'h0051) begin
      errors++; $display("FAIL sqrt_load_data: got %h required 0051", load_q[0]);
    end
    checks++;
    if (start_op !== OP_SQRT) begin errors++; $display("FAIL sqrt_op: got %b required 1", start_op); end
    @(negedge clk);
  endtask

  task automatic test_error();
    exp_t e; int lat; bit ok;
    set_model(1, 2, 2, 0, 0, 0, 1, 32'h0000_00B5);
    e.res = 32'h0000_00B5; e.err = 1'b1; e.to = 1'b0; sb.push_back(e);
    send_req(OP_SQRT, 16'h8000, 16'h0000);
    wait_rsp(lat, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL err_rsp_valid: got %b required 1", rsp_valid); end
    e = sb.pop_front();
    checks++;
    if (rsp_result !== e.res || rsp_error !== e.err || rsp_timeout !== e.to) begin
      errors++;
      $display("FAIL err_rsp: got %h/%b/%b required %h/%b/%b",
               rsp_result, rsp_error, rsp_timeout, e.res, e.err, e.to);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    exp_t e; int lat; bit ok; int l0, rcyc;
    set_model(1, 2, 1, 1, 0, 0, 0, 32'h1234_5678);
    l0 = load_count;
    e.res = '0; e.err = 1'b1; e.to = 1'b1; sb.push_back(e);
    send_req(OP_MULT, 16'h1234, 16'h5678);
    wait_rsp(lat, ok);
    rcyc = cyc;
    checks++;
    if (!ok || rcyc != load_cycle + TO + 1) begin
      errors++;
      $display("FAIL timeout_entry: resp at cycle %0d required %0d", rcyc, load_cycle + TO + 1);
    end
    e = sb.pop_front();
    checks++;
    if (rsp_result !== e.res || rsp_error !== e.err || rsp_timeout !== e.to) begin
      errors++;
      $display("FAIL timeout_rsp: got %h/%b/%b required %h/%b/%b",
               rsp_result, rsp_error, rsp_timeout, e.res, e.err, e.to);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (load_count - l0 != 1) begin
      errors++; $display("FAIL timeout_loads: got %0d required 1", load_count - l0);
    end
  endtask

  task automatic test_backpressure_reset();
    exp_t e; int lat; bit ok, stable; int n;
    set_model(1, 2, 1, 0, 0, 0, 0, 32'h0000_0005);
    rsp_ready = 1'b0;
    e.res = 32'h0000_0005; e.err = 1'b0; e.to = 1'b0; sb.push_back(e);
    send_req(OP_SQRT, 16'h0019, 16'h0000);
    wait_rsp(lat, ok);
    e = sb.pop_front();
    stable = ok;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid !== 1'b1 || rsp_result !== e.res || req_ready !== 1'b0) stable = 0;
      @(negedge clk);
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL bp_hold: valid=%b result=%h req_ready=%b required 1/%h/0", rsp_valid, rsp_result, req_ready, e.res);
    end
    rsp_ready = 1'b1;
    @(negedge clk);

    set_model(1, 2, 1, 0, 1, 0, 0, 32'h0000_0007);
    send_req(OP_SQRT, 16'h0031, 16'h0000);
    n = 0;
    while (mrc_load !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || mrc_op !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rst_wait_rdy: busy=%b op=%b valid=%b required 1/1/0", busy, mrc_op, rsp_valid);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 ||
        {busy, rsp_valid, rsp_error, rsp_timeout, mrc_start, mrc_load, mrc_op} !== 7'b0 ||
        rsp_result !== '0 || mrc_data !== '0) begin
      errors++;
      $display("FAIL rst_abort: req_ready=%b flags=%b result=%h data=%h required 1/0/0/0", req_ready,
               {busy, rsp_valid, rsp_error, rsp_timeout, mrc_start, mrc_load, mrc_op}, rsp_result, mrc_data);
    end
    reset = 1'b0;
    stable = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) stable = 0;
    end
    checks++;
    if (!stable) begin errors++; $display("FAIL rst_no_rsp: valid=%b required 0", rsp_valid); end
  endtask

  task automatic test_stray();
    exp_t e; int lat; bit ok; int l0;
    set_model(2, 2, 3, 0, 0, 1, 0, 32'h0000_003F);
    l0 = load_count;
    e.res = 32'h0000_003F; e.err = 1'b0; e.to = 1'b0; sb.push_back(e);
    send_req(OP_MULT, 16'h0007, 16'h0009);
    wait_rsp(lat, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stray_rsp_valid: got %b required 1", rsp_valid); end
    e = sb.pop_front();
    checks++;
    if (rsp_result !== e.res || rsp_error !== e.err || rsp_timeout !== e.to) begin
      errors++;
      $display("FAIL stray_rsp: got %h/%b/%b required %h/%b/%b",
               rsp_result, rsp_error, rsp_timeout, e.res, e.err, e.to);
    end
    checks++;
    if (load_count - l0 != 2) begin
      errors++; $display("FAIL stray_loads: got %0d required 2", load_count - l0);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    exp_t e; int lat; bit ok;
    set_model(1, 2, 1, 0, 0, 0, 0, 32'h0000_0004);
    e.res = 32'h0000_0004; e.err = 1'b0; e.to = 1'b0; sb.push_back(e);
    send_req(OP_SQRT, 16'h0010, 16'h0000);
    wait_rsp(lat, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || rsp_result !== e.res) begin
      errors++; $display("FAIL b2b_first: got %h required %h", rsp_result, e.res);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_idle_gap: req_ready=%b busy=%b required 1/0", req_ready, busy);
    end
    set_model(1, 2, 1, 0, 0, 0, 0, 32'h0000_0006);
    e.res = 32'h0000_0006; e.err = 1'b0; e.to = 1'b0; sb.push_back(e);
    send_req(OP_SQRT, 16'h0024, 16'h0000);
    wait_rsp(lat, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || lat != 5 || rsp_result !== e.res) begin
      errors++; $display("FAIL b2b_second: got %h lat %0d required %h lat 5", rsp_result, lat, e.res);
    end
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_empty: %0d entries left required 0", sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_mult();
    test_sqrt();
    test_error();
    test_timeout();
    test_backpressure_reset();
    test_stray();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
